// File: rtl/mlp_hls_deadlock_report.sv
// mlp_hls_deadlock_report
//
// Watches the one-bit `block` indication from a dataflow deadlock monitor.
// A deadlock is declared only after `block` is seen high for THRESHOLD
// consecutive cycles. When that happens, a diagnostic snapshot is taken:
// the instance and AXIS block vectors plus the cycle timestamp. The snapshot
// is offered exactly once on a valid/ready report channel. A sticky deadlock
// flag stays high until software pulses `clear`.
//
// Optional feature: define MLP_DEADLOCK_REPORT_EVENT_CNT_EN to add an 8-bit
// saturating count of detections (event_count).
//
// Report channel handshake: the payload transfers on a rising edge where
// report_valid and report_ready are both high. Once report_valid is high, it
// and the payload stay stable until that transfer. report_ready may change
// at any time.
//
// Ports:
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   block           in   deadlock-candidate indication
//   inst_block_sigs in   [NUM_INST] per-instance block vector (snapshotted)
//   axis_block_sigs in   [NUM_AXIS] AXIS block vector (snapshotted)
//   clear           in   one-cycle software clear
//   report_valid    out  report payload valid
//   report_ready    in   collector accepts report
//   report_inst     out  [NUM_INST] captured inst_block_sigs
//   report_axis     out  [NUM_AXIS] captured axis_block_sigs
//   report_ts       out  [TS_W] timestamp of the final qualifying cycle
//   deadlock_flag   out  sticky deadlock indication
//   event_count     out  [8] saturating detection count (optional)
//   dbg_state       out  [2] FSM state (0 IDLE, 1 COUNT, 2 REPORT, 3 HOLD)
module mlp_hls_deadlock_report #(
  parameter int THRESHOLD = 1024,
  parameter int NUM_INST  = 13,
  parameter int NUM_AXIS  = 2,
  parameter int TS_W      = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                block,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [NUM_INST-1:0] report_inst,
  output logic [NUM_AXIS-1:0] report_axis,
  output logic [TS_W-1:0]     report_ts,
  output logic                deadlock_flag,
`ifdef MLP_DEADLOCK_REPORT_EVENT_CNT_EN
  output logic [7:0]          event_count,
`endif
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [15:0] LP_THR_M1  = 16'(THRESHOLD - 1);
  localparam bit          LP_THR_ONE = (THRESHOLD == 1);

  state_t              r_state;
  logic [15:0]         r_streak;
  logic [TS_W-1:0]     r_ts;
  logic                r_valid;
  logic                r_flag;
  logic [NUM_INST-1:0] r_inst;
  logic [NUM_AXIS-1:0] r_axis;
  logic [TS_W-1:0]     r_rep_ts;
  logic                w_enter_report;
`ifdef MLP_DEADLOCK_REPORT_EVENT_CNT_EN
  logic [7:0]          r_evt;
`endif

  // High in the final qualifying cycle. On the next edge the FSM enters
  // REPORT. clear takes priority over block in IDLE/COUNT.
  assign w_enter_report = block && !clear &&
                          (((r_state == ST_IDLE) && LP_THR_ONE) ||
                           ((r_state == ST_COUNT) && (r_streak == LP_THR_M1)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_streak <= 16'd0;
      r_ts     <= '0;
      r_valid  <= 1'b0;
      r_flag   <= 1'b0;
      r_inst   <= '0;
      r_axis   <= '0;
      r_rep_ts <= '0;
`ifdef MLP_DEADLOCK_REPORT_EVENT_CNT_EN
      r_evt    <= 8'd0;
`endif
    end else begin
      r_ts <= r_ts + 1'b1;

      // The snapshot uses the timestamp of the qualifying cycle, before
      // this edge increments it.
      if (w_enter_report) begin
        r_inst   <= inst_block_sigs;
        r_axis   <= axis_block_sigs;
        r_rep_ts <= r_ts;
`ifdef MLP_DEADLOCK_REPORT_EVENT_CNT_EN
        if (r_evt != 8'hFF) r_evt <= r_evt + 8'd1;
`endif
      end

      case (r_state)
        ST_IDLE: begin
          r_streak <= 16'd0;
          if (w_enter_report) begin
            r_state <= ST_REPORT;
            r_valid <= 1'b1;
            r_flag  <= 1'b1;
          end else if (block && !clear) begin
            r_state  <= ST_COUNT;
            r_streak <= 16'd1;
          end
        end
        ST_COUNT: begin
          if (clear || !block) begin
            r_state  <= ST_IDLE;
            r_streak <= 16'd0;
          end else if (w_enter_report) begin
            r_state  <= ST_REPORT;
            r_streak <= 16'd0;
            r_valid  <= 1'b1;
            r_flag   <= 1'b1;
          end else begin
            r_streak <= r_streak + 16'd1;
          end
        end
        ST_REPORT: begin
          // clear is honoured only together with acceptance, so a pending
          // report is never dropped.
          if (report_ready) begin
            r_valid <= 1'b0;
            if (clear) begin
              r_state <= ST_IDLE;
              r_flag  <= 1'b0;
            end else begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (clear) begin
            r_state <= ST_IDLE;
            r_flag  <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_streak <= 16'd0;
          r_valid  <= 1'b0;
          r_flag   <= 1'b0;
        end
      endcase
    end
  end

  assign report_valid  = r_valid;
  assign report_inst   = r_inst;
  assign report_axis   = r_axis;
  assign report_ts     = r_rep_ts;
  assign deadlock_flag = r_flag;
  assign dbg_state     = r_state;
`ifdef MLP_DEADLOCK_REPORT_EVENT_CNT_EN
  assign event_count   = r_evt;
`endif

endmodule

// File: doc/mlp_hls_deadlock_report.md
Name: mlp_hls_deadlock_report

Overview:
- Downstream consumer of the per-dataflow deadlock monitor's one-bit `block` output.
- Qualifies `block` against a consecutive-cycle threshold so single-cycle stalls are filtered out.
- On confirmed deadlock: captures a diagnostic snapshot (instance block vector, AXIS block vector, cycle timestamp) and presents it once on a valid/ready report channel to the debug/CSR collector.
- Holds a sticky deadlock flag until software clears it.

Parameters:
- THRESHOLD, 1024: consecutive cycles `block` must be sampled high before deadlock is declared; legal range 1..65535.
- NUM_INST, 13: width of the instance block vector.
- NUM_AXIS, 2: width of the AXIS block vector.
- TS_W, 32: width of the free-running cycle timestamp.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- block  in  1  deadlock-candidate indication from the monitor.
- inst_block_sigs  in  NUM_INST  per-instance channel-block vector, snapshotted on detection.
- axis_block_sigs  in  NUM_AXIS  AXIS-block vector, snapshotted on detection.
- clear  in  1  one-cycle software clear.
- report_valid  out  1  report payload valid.
- report_ready  in  1  collector accepts report.
- report_inst  out  NUM_INST  captured inst_block_sigs.
- report_axis  out  NUM_AXIS  captured axis_block_sigs.
- report_ts  out  TS_W  timestamp of detection cycle.
- deadlock_flag  out  1  sticky deadlock indication.

Behaviour:
- Reset: reset_n low asynchronously forces the following:
  - state IDLE;
  - streak=0, ts counter=0;
  - report_valid=0, deadlock_flag=0;
  - report_inst/axis/ts all 0.
- Timestamp counter: increments every cycle out of reset, wraps from 2^TS_W-1 to 0 and never stops.
- Streak counter: 16 bits; counts consecutive cycles in which `block` is sampled 1.
- State machine:
  - IDLE:
    - block=1 and THRESHOLD=1 -> REPORT.
    - block=1 otherwise -> COUNT, streak=1.
    - block=0 -> stay, streak=0.
  - COUNT:
    - block=0 -> IDLE, streak=0.
    - block=1 and streak==THRESHOLD-1 -> REPORT.
    - block=1 otherwise -> streak+1.
  - REPORT:
    - report_valid=1, deadlock_flag=1, payload held stable.
    - report_ready=1 -> HOLD (report_valid drops the next cycle).
    - `block` is ignored.
  - HOLD:
    - report_valid=0, deadlock_flag=1.
    - clear=1 -> IDLE, flag drops the next cycle.
    - `block` is ignored.
- Snapshot capture:
  - Taken on the clock edge that enters REPORT.
  - Captures inst_block_sigs, axis_block_sigs and the ts counter value as sampled in the final qualifying cycle.
  - Payload registers are not modified again until the next entry to REPORT; they are not cleared by `clear`.
- Latency: with `block` held high from cycle 0, report_valid rises at cycle THRESHOLD (registered output).
- Clear handling:
  - IDLE/COUNT: clear forces IDLE and streak=0, overriding block=1 in the same cycle.
  - REPORT with report_ready=0: clear is ignored; a report is never dropped.
  - REPORT with report_ready=1: clear and ready together go directly to IDLE.
- Valid/ready rules:
  - report_valid never deasserts without report_ready.
  - Exactly one report is issued per detection.
  - Re-detection requires `clear` followed by a fresh qualifying streak.
- Reset mid-operation (e.g. in REPORT): report is discarded and all outputs take their reset values immediately.

Optional Feature:
- Macro: MLP_DEADLOCK_REPORT_EVENT_CNT_EN.
- When defined:
  - Adds output `event_count`, 8 bits.
  - Increments on each entry to REPORT, saturates at 255.
  - Cleared only by reset_n, not by `clear`.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- THRESHOLD=4; block high cycles 0-3 with inst_block_sigs=13'h1ABC, axis=2'b01 at cycle 3 -> report_valid=1 at cycle 4, report_inst=13'h1ABC, report_axis=2'b01, report_ts=3, deadlock_flag=1.
- THRESHOLD=4; block pattern 1,1,1,0,1,1,1,0 -> report_valid and deadlock_flag never assert.
- In REPORT, hold report_ready=0 for 10 cycles with clear pulsed -> report_valid and payload stable throughout; ready=1 -> HOLD; subsequent clear -> deadlock_flag=0 one cycle later.
- THRESHOLD=1; block single-cycle pulse -> report_valid next cycle; ready and clear asserted together -> IDLE, flag=0.
- reset_n pulled low asynchronously mid-REPORT -> report_valid=0, deadlock_flag=0 without waiting for a clock edge; ts restarts from 0.
- With MLP_DEADLOCK_REPORT_EVENT_CNT_EN: 257 detect/ack/clear cycles -> event_count=255; after an extra clear, event_count is still 255.
